// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//   Instruction-fetch end of the single-cycle control path. Owns the PC,
//   fetches 16-bit instructions over a req/ack imem port, presents each one
//   to the control unit for a single EXEC cycle, then commits the next PC
//   chosen by pc_sel. Halts on hlt_rst=0 and resumes on request. A fetch
//   that is not acknowledged within ACK_TIMEOUT wait cycles raises a sticky
//   fetch_fault and parks the sequencer in HALT.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   ACK_TIMEOUT  max WAIT cycles before fault; 0 disables the timeout
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request, held until ack
//   imem_addr    out  16  word address of fetch (= pc)
//   imem_rdata   in   16  instruction word, valid with imem_ack
//   imem_ack     in   1   fetch complete; only looked at in FETCH/WAIT
//   instr        out  16  instruction register
//   instr_valid  out  1   high exactly during EXEC
//   pc_sel       in   2   00 PC+1, 01 rs_data, 10 branch, 11 jump
//   hlt_rst      in   1   0 = halt request (sampled in EXEC only)
//   rs_data      in   16  register rs value for jump-register
//   pc           out  16  current PC
//   link_addr    out  16  PC+1, for jump-and-link writeback
//   halted       out  1   high in HALT
//   fetch_fault  out  1   sticky ack-timeout flag, cleared by reset only
//   resume       in   1   leave HALT (ignored while fetch_fault=1)
//
// State | meaning
// ------+-----------------------------------------------------------------
// FETCH | request instruction at pc; accept a zero-wait ack
// WAIT  | request held, counting cycles until ack or timeout
// EXEC  | instruction presented for one cycle; next PC committed at its end
// HALT  | parked; pc frozen, no request, wait for resume
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ack,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic [1:0]  pc_sel,
   input  logic        hlt_rst,
   input  logic [15:0] rs_data,
   output logic [15:0] pc,
   output logic [15:0] link_addr,
   output logic        halted,
   output logic        fetch_fault,
   input  logic        resume
);

   localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LIMIT = CW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_pc;
   logic [15:0]     r_ir;
   logic [CW-1:0]   r_cnt;
   logic            r_req;
   logic            r_fault;

   logic            w_req_nxt;
   logic            w_instr_valid;
   logic            w_halted;
   logic            w_timeout;
   logic [15:0]     w_pc_p1;
   logic [15:0]     w_branch_off;
   logic [15:0]     w_next_pc;

   assign w_pc_p1      = r_pc + 16'd1;
   assign w_branch_off = {{9{r_ir[6]}}, r_ir[6:0]};
   assign w_timeout    = (ACK_TIMEOUT != 0) && (r_cnt == TO_LIMIT);

   always_comb begin
      w_next_pc = w_pc_p1;
      case (pc_sel)
         2'b00:   w_next_pc = w_pc_p1;
         2'b01:   w_next_pc = rs_data;
         2'b10:   w_next_pc = w_pc_p1 + w_branch_off;
         2'b11:   w_next_pc = {w_pc_p1[15:13], r_ir[12:0]};
         default: w_next_pc = w_pc_p1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. The request is registered, so the first FETCH after
   // reset is a dead cycle with req low; an ack there must not be taken.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: begin
            if (r_req && imem_ack) begin
               w_state_nxt = S_EXEC;
            end else if (r_req) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               w_state_nxt = S_EXEC;
            end else if (w_timeout) begin
               w_state_nxt = S_HALT;
            end
         end
         S_EXEC: begin
            w_state_nxt = hlt_rst ? S_FETCH : S_HALT;
         end
         S_HALT: begin
            if (resume && !r_fault) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   // Output logic. Request is computed from the next state and registered so
   // it rises exactly on entry into FETCH and drops on entry into EXEC/HALT.
   always_comb begin
      w_req_nxt     = 1'b0;
      w_instr_valid = 1'b0;
      w_halted      = 1'b0;
      if (w_state_nxt == S_FETCH || w_state_nxt == S_WAIT) begin
         w_req_nxt = 1'b1;
      end
      if (r_state == S_EXEC) begin
         w_instr_valid = 1'b1;
      end
      if (r_state == S_HALT) begin
         w_halted = 1'b1;
      end
   end

   // Datapath: PC, IR, wait counter, request and fault flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_ir    <= 16'h0000;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_req <= w_req_nxt;
         case (r_state)
            S_FETCH: begin
               if (r_req && imem_ack) begin
                  r_ir <= imem_rdata;
               end else if (r_req) begin
                  r_cnt <= CW'(1);
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  r_ir <= imem_rdata;
               end else if (w_timeout) begin
                  r_fault <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_EXEC: begin
               // A halting instruction still advances past itself; pc_sel is
               // don't-care in that case.
               r_pc <= hlt_rst ? w_next_pc : w_pc_p1;
            end
            default: begin
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_ir;
   assign instr_valid = w_instr_valid;
   assign pc          = r_pc;
   assign link_addr   = w_pc_p1;
   assign halted      = w_halted;
   assign fetch_fault = r_fault;

endmodule
